// File: rtl/led_arbiter_if.sv
// Request/grant bundle between the status sources and led_arbiter.
// Requesters drive req/count; the arbiter reports ack, done, owner and busy.
interface led_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] count;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       done;
    logic [OW-1:0]         owner;
    logic                  busy;

    modport master (output req, count, input ack, done, owner, busy);
    modport slave  (input req, count, output ack, done, owner, busy);
endinterface

// File: rtl/led_arbiter.sv
// Round-robin sharing of the single status LED: each grantee gets a burst of
// N blinks (ON/OFF phases) followed by a dark GAP before completion.
module led_arbiter #(
    parameter int NREQ       = 4,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 4,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic           clk,
    input  logic           rst,
    led_arbiter_if.slave   bus,
    output logic           led1
);
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAX2 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int MAXC = (MAX2 > GAP_CYCLES) ? MAX2 : GAP_CYCLES;
    localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    phase_reg, phase_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [OW-1:0]    ptr_reg, ptr_next;
    logic [OW-1:0]    owner_reg, owner_next;
    logic [NREQ-1:0]  ack_reg, ack_next;
    logic [NREQ-1:0]  done_reg, done_next;
    logic             busy_reg;
    logic             led_reg;

    logic [CNT_W-1:0] cnt_arr [NREQ];
    logic             grant_valid;
    logic [OW-1:0]    grant_idx;
    logic [OW-1:0]    cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
        assign cnt_arr[gi] = bus.count[gi*CNT_W +: CNT_W];
    end

    // Search downward so the candidate closest to ptr+1 is assigned last and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int j = NREQ; j >= 1; j--) begin
            cand = OW'((int'(ptr_reg) + j) % NREQ);
            if (bus.req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        remaining_next = remaining_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        ack_next       = '0;
        done_next      = '0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    ack_next[grant_idx] = 1'b1;
                    owner_next          = grant_idx;
                    ptr_next            = grant_idx;
                    remaining_next      = cnt_arr[grant_idx];
                    if (cnt_arr[grant_idx] != '0) begin
                        state_next = ON;
                        phase_next = PW'(ON_CYCLES - 1);
                    end else begin
                        state_next = GAP;
                        phase_next = PW'(GAP_CYCLES - 1);
                    end
                end
            end
            ON: begin
                if (phase_reg == '0) begin
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = GAP;
                        phase_next = PW'(GAP_CYCLES - 1);
                    end else begin
                        state_next = OFF;
                        phase_next = PW'(OFF_CYCLES - 1);
                    end
                end else begin
                    phase_next = phase_reg - PW'(1);
                end
            end
            OFF: begin
                if (phase_reg == '0) begin
                    state_next = ON;
                    phase_next = PW'(ON_CYCLES - 1);
                end else begin
                    phase_next = phase_reg - PW'(1);
                end
            end
            GAP: begin
                if (phase_reg == '0) begin
                    state_next           = IDLE;
                    done_next[owner_reg] = 1'b1;
                end else begin
                    phase_next = phase_reg - PW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // led1 and busy follow the next state so they change on the same edge as ack/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            remaining_reg <= '0;
            ptr_reg       <= OW'(NREQ - 1);
            owner_reg     <= '0;
            ack_reg       <= '0;
            done_reg      <= '0;
            busy_reg      <= 1'b0;
            led_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            remaining_reg <= remaining_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            ack_reg       <= ack_next;
            done_reg      <= done_next;
            busy_reg      <= (state_next != IDLE);
            led_reg       <= (state_next == ON);
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.done  = done_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = busy_reg;
    assign led1      = led_reg;
endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter: single-burst vector table plus hand-written
// round-robin, fairness, late/dropped request and mid-burst reset sequences.
module tb_led_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led1;

    led_arbiter_if #(.NREQ(4), .CNT_W(4)) bus ();

    led_arbiter #(.NREQ(4), .ON_CYCLES(4), .OFF_CYCLES(4), .GAP_CYCLES(8), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .led1 (led1)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] count;
        logic [3:0]  exp_ack;
        int          exp_owner;
        int          exp_len;
        int          exp_on;
    } vec_t;

    vec_t vec [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for a nonzero ack or done sample; counts led1-high samples on the way.
    task automatic wait_for(input bit want_done, input int budget, output int cyc,
                            output logic [3:0] val, output int hi);
        cyc = 0;
        hi  = 0;
        val = '0;
        while (cyc < budget && val == '0) begin
            @(negedge clk);
            cyc++;
            if (led1) hi++;
            val = want_done ? bus.done : bus.ack;
        end
        if (val == '0) check(want_done ? "done_timeout" : "ack_timeout", 32'(cyc), 32'(budget + 1));
    endtask

    int         cyc, hi, on_cnt, bad;
    logic [3:0] val;

    initial begin
        vec[0] = '{4'b0100, 16'h0300, 4'b0100, 2, 28, 12};
        vec[1] = '{4'b0010, 16'h0000, 4'b0010, 1, 8, 0};
        vec[2] = '{4'b0001, 16'h0001, 4'b0001, 0, 12, 4};
        vec[3] = '{4'b1000, 16'hF000, 4'b1000, 3, 124, 60};
        vec[4] = '{4'b1010, 16'h2020, 4'b0010, 1, 20, 8};
        vec[5] = '{4'b0101, 16'h0101, 4'b0100, 2, 12, 4};
        vec[6] = '{4'b0011, 16'h0012, 4'b0001, 0, 20, 8};

        bus.req   = '0;
        bus.count = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_idle", {bus.ack, bus.done, 30'(bus.owner), bus.busy, led1}, '0);
        end
        $display("[TB] reset: outputs idle for 20 cycles");

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            bus.req   = vec[v].req;
            bus.count = vec[v].count;
            wait_for(1'b0, 10, cyc, val, hi);
            check("vec_ack", 32'(val), 32'(vec[v].exp_ack));
            check("vec_ack_latency", 32'(cyc), 32'd1);
            check("vec_owner", 32'(bus.owner), 32'(vec[v].exp_owner));
            check("vec_busy", 32'(bus.busy), 32'd1);
            check("vec_led_at_ack", 32'(led1), 32'(vec[v].exp_on != 0));
            on_cnt  = int'(led1);
            bus.req = '0;
            wait_for(1'b1, 200, cyc, val, hi);
            check("vec_len", 32'(cyc), 32'(vec[v].exp_len));
            check("vec_led_on", 32'(on_cnt + hi), 32'(vec[v].exp_on));
            check("vec_done", 32'(val), 32'(vec[v].exp_ack));
            check("vec_busy_end", 32'(bus.busy), 32'd0);
            check("vec_owner_end", 32'(bus.owner), 32'(vec[v].exp_owner));
            $display("[TB] vec %0d: req=%b owner=%0d len=%0d on=%0d", v, vec[v].req, bus.owner, cyc, on_cnt + hi);
        end

        // Round-robin from a fresh pointer
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req   = 4'b1111;
        bus.count = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            wait_for(1'b0, 10, cyc, val, hi);
            check("rr_ack", 32'(val), 32'(4'b0001 << (i % 4)));
            check("rr_gap", 32'(cyc), 32'd1);
            if (i == 4) bus.req = '0;
            wait_for(1'b1, 50, cyc, val, hi);
            check("rr_len", 32'(cyc), 32'd12);
            $display("[TB] rr grant %0d: done=%b len=%0d", i, val, cyc);
        end

        // Fairness: pointer to 1, then req 0 and 1 held
        @(negedge clk);
        bus.req   = 4'b0010;
        bus.count = 16'h0000;
        wait_for(1'b0, 10, cyc, val, hi);
        check("fair_setup_ack", 32'(val), 32'(4'b0010));
        bus.req = '0;
        wait_for(1'b1, 30, cyc, val, hi);
        check("fair_setup_len", 32'(cyc), 32'd8);
        @(negedge clk);
        bus.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            wait_for(1'b0, 10, cyc, val, hi);
            check("fair_ack", 32'(val), (i == 1) ? 32'(4'b0010) : 32'(4'b0001));
            if (i == 2) bus.req = '0;
            wait_for(1'b1, 30, cyc, val, hi);
            check("fair_len", 32'(cyc), 32'd8);
            $display("[TB] fairness grant %0d: done=%b", i, val);
        end

        // Late request for 3 and a dropped pulse on 2, both inside a burst of 0
        @(negedge clk);
        bus.req   = 4'b0001;
        bus.count = 16'h1002;
        wait_for(1'b0, 10, cyc, val, hi);
        check("late_ack0", 32'(val), 32'(4'b0001));
        bus.req = '0;
        repeat (3) @(negedge clk);
        bus.req[3] = 1'b1;
        repeat (2) @(negedge clk);
        bus.req[2] = 1'b1;
        repeat (3) @(negedge clk);
        bus.req[2] = 1'b0;
        wait_for(1'b1, 40, cyc, val, hi);
        check("late_done0", 32'(val), 32'(4'b0001));
        wait_for(1'b0, 10, cyc, val, hi);
        check("late_ack3", 32'(val), 32'(4'b1000));
        check("late_ack3_gap", 32'(cyc), 32'd1);
        bus.req = '0;
        wait_for(1'b1, 40, cyc, val, hi);
        check("late_len3", 32'(cyc), 32'd12);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ack != '0) bad++;
        end
        check("dropped_req2", 32'(bad), 32'd0);
        $display("[TB] late/drop: req3 served after req0, req2 pulse ignored");

        // Mid-burst asynchronous reset
        @(negedge clk);
        bus.req   = 4'b0001;
        bus.count = 16'h0003;
        wait_for(1'b0, 10, cyc, val, hi);
        check("abort_ack", 32'(val), 32'(4'b0001));
        bus.req = '0;
        repeat (2) @(negedge clk);
        check("abort_led_before", 32'(led1), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_async", {29'(bus.ack), led1, bus.busy}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done != '0 || bus.busy || led1) bad++;
        end
        check("abort_no_done", 32'(bad), 32'd0);
        $display("[TB] mid-burst reset: burst aborted without done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
